// File: rtl/vga_timing_gen.sv
// Raster timing source: walks a (h, v) position one pixel per en_i strobe and
// presents registered sync, data-enable, coordinates and line/frame pulses,
// all describing the same position in the same cycle.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter logic        SYNC_POL    = 1'b0,
   parameter int unsigned COORD_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_i,
   output logic                   hsync_o,
   output logic                   vsync_o,
   output logic                   de_o,
   output logic [COORD_WIDTH-1:0] x_o,
   output logic [COORD_WIDTH-1:0] y_o,
   output logic                   line_start_o,
   output logic                   frame_start_o
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_WIDTH-1:0] HLast      = COORD_WIDTH'(H_TOTAL - 1);
   localparam logic [COORD_WIDTH-1:0] VLast      = COORD_WIDTH'(V_TOTAL - 1);
   localparam logic [COORD_WIDTH-1:0] HAct       = COORD_WIDTH'(H_ACTIVE);
   localparam logic [COORD_WIDTH-1:0] VAct       = COORD_WIDTH'(V_ACTIVE);
   localparam logic [COORD_WIDTH-1:0] HSyncFirst = COORD_WIDTH'(H_ACTIVE + H_FP);
   localparam logic [COORD_WIDTH-1:0] HSyncLast  = COORD_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_WIDTH-1:0] VSyncFirst = COORD_WIDTH'(V_ACTIVE + V_FP);
   localparam logic [COORD_WIDTH-1:0] VSyncLast  = COORD_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [COORD_WIDTH-1:0] h_q, h_d, v_q, v_d;
   logic [COORD_WIDTH-1:0] h_nxt, v_nxt;
   logic                   de_q, de_d;
   logic                   hsync_q, hsync_d;
   logic                   vsync_q, vsync_d;
   logic                   line_start_q, line_start_d;
   logic                   frame_start_q, frame_start_d;
   logic                   h_wrap, v_wrap;

   // Position one strobe ahead; wraps h at end of line, v at end of frame.
   always_comb begin
      h_wrap = (h_q == HLast);
      v_wrap = (v_q == VLast);
      h_nxt  = h_wrap ? '0 : h_q + COORD_WIDTH'(1);
      v_nxt  = v_q;
      if (h_wrap) begin
         v_nxt = v_wrap ? '0 : v_q + COORD_WIDTH'(1);
      end
   end

   // Decode outputs from the next position on a strobe; hold otherwise, pulses drop.
   always_comb begin
      h_d           = h_q;
      v_d           = v_q;
      de_d          = de_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (en_i) begin
         h_d           = h_nxt;
         v_d           = v_nxt;
         de_d          = (h_nxt < HAct) && (v_nxt < VAct);
         hsync_d       = ((h_nxt >= HSyncFirst) && (h_nxt <= HSyncLast)) ? SYNC_POL : ~SYNC_POL;
         vsync_d       = ((v_nxt >= VSyncFirst) && (v_nxt <= VSyncLast)) ? SYNC_POL : ~SYNC_POL;
         line_start_d  = (h_nxt == '0);
         frame_start_d = (h_nxt == '0) && (v_nxt == '0);
      end
   end

   // State registers; reset parks on the last pixel so the first strobe shows (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q           <= HLast;
         v_q           <= VLast;
         de_q          <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x_o           = h_q;
   assign y_o           = v_q;
   assign de_o          = de_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

endmodule
